// File: rtl/p4_router_ingress_mtu_guard.sv
// p4_router_ingress_mtu_guard: per-packet MTU truncation, optional runt flagging (macro P4_ROUTER_ING_GUARD_RUNT_CHECK_EN), enable gate and stats
module p4_router_ingress_mtu_guard #(
    parameter int MTU_BYTES              = 1500,
    parameter int MIN_PKT_BYTES          = 14,
    parameter int COUNTER_WIDTH          = 32,
    parameter int DATA_BYTES             = 64,
    parameter int USER_WIDTH             = 4,
    parameter int NUM_ING_PHYS_PORTS_LOG = 2
) (
    input  logic                       clk,
    input  logic                       sreset,
    input  logic [DATA_BYTES*8-1:0]    ing_tdata,
    input  logic [DATA_BYTES-1:0]      ing_tkeep,
    input  logic [USER_WIDTH-1:0]      ing_tuser,
    input  logic                       ing_tlast,
    input  logic                       ing_tvalid,
    output logic                       ing_tready,
    output logic [DATA_BYTES*8-1:0]    vnp4_tdata,
    output logic [DATA_BYTES-1:0]      vnp4_tkeep,
    output logic [USER_WIDTH-1:0]      vnp4_tuser,
    output logic                       vnp4_tlast,
    output logic                       vnp4_tvalid,
    input  logic                       vnp4_tready,
    input  logic                       enable,
    input  logic                       cnts_clear,
    output logic [COUNTER_WIDTH-1:0]   pkt_cnt,
    output logic [COUNTER_WIDTH-1:0]   oversize_cnt,
    output logic [COUNTER_WIDTH-1:0]   runt_cnt,
    output logic [COUNTER_WIDTH-1:0]   discard_beat_cnt
);
    localparam int LW = $clog2(MTU_BYTES + DATA_BYTES + 1);
    localparam int BW = $clog2(DATA_BYTES + 1);
    localparam int PW = DATA_BYTES * 9 + USER_WIDTH + 1;

    if (USER_WIDTH < NUM_ING_PHYS_PORTS_LOG + 1) begin : g_bad_user
        $error("USER_WIDTH must hold the port index plus the error flag");
    end
    if (MIN_PKT_BYTES > DATA_BYTES || DATA_BYTES > MTU_BYTES) begin : g_bad_len
        $error("need MIN_PKT_BYTES <= DATA_BYTES <= MTU_BYTES");
    end

    typedef enum logic {PASS, DISCARD} state_t;
    state_t state, state_n;
    logic [BW-1:0] beat_bytes;
    logic [LW-1:0] len, len_n, next_len;
    logic ovs, runt, acc, push, pop, tready_q;
    logic [1:0] cnt, cnt_n;
    logic [PW-1:0] in_beat, e0, e1;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] c, input logic inc);
        return (inc && !(&c)) ? c + COUNTER_WIDTH'(1) : c;
    endfunction

    // byte count of the current beat; tkeep is LSB-contiguous so popcount is the length
    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < DATA_BYTES; i++) beat_bytes = beat_bytes + BW'(ing_tkeep[i]);
    end

    assign next_len = len + LW'(beat_bytes);
    assign ovs      = next_len > LW'(MTU_BYTES);
`ifdef P4_ROUTER_ING_GUARD_RUNT_CHECK_EN
    assign runt     = ing_tlast && next_len < LW'(MIN_PKT_BYTES);
`else
    assign runt     = 1'b0;
`endif
    assign acc      = ing_tvalid && tready_q;
    assign push     = acc && state == PASS;
    assign pop      = vnp4_tvalid && vnp4_tready;
    assign cnt_n    = cnt + 2'(push) - 2'(pop);
    assign in_beat  = {ing_tlast || ovs, ing_tuser[USER_WIDTH-1] || ovs || runt,
                       ing_tuser[USER_WIDTH-2:0], ing_tkeep, ing_tdata};
    assign state_n  = push ? ((ovs && !ing_tlast) ? DISCARD : PASS) : (acc && ing_tlast) ? PASS : state;
    assign len_n    = push ? ((ing_tlast || ovs) ? '0 : next_len) : len;

    assign ing_tready  = tready_q;
    assign vnp4_tvalid = cnt != 2'd0;
    assign {vnp4_tlast, vnp4_tuser, vnp4_tkeep, vnp4_tdata} = e0;

    // packet state, running length and registered upstream ready (gate applies only between packets)
    always_ff @(posedge clk) begin
        if (sreset) begin
            state    <= PASS;
            len      <= '0;
            tready_q <= 1'b0;
        end else begin
            state    <= state_n;
            len      <= len_n;
            tready_q <= state_n == DISCARD || (cnt_n != 2'd2 && (len_n != '0 || enable));
        end
    end

    // two-entry skid buffer, head always in e0 so the output payload only moves on a pop
    always_ff @(posedge clk) begin
        cnt <= sreset ? 2'd0 : cnt_n;
        if (push && cnt == 2'(pop)) e0 <= in_beat;
        else if (pop) e0 <= e1;
        if (push && cnt == 2'(pop) + 2'd1) e1 <= in_beat;
    end

    // saturating statistics; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (sreset || cnts_clear) begin
            pkt_cnt          <= '0;
            oversize_cnt     <= '0;
            discard_beat_cnt <= '0;
        end else begin
            pkt_cnt          <= sat_inc(pkt_cnt, pop && vnp4_tlast);
            oversize_cnt     <= sat_inc(oversize_cnt, push && ovs);
            discard_beat_cnt <= sat_inc(discard_beat_cnt, acc && state == DISCARD);
        end
    end

`ifdef P4_ROUTER_ING_GUARD_RUNT_CHECK_EN
    // runt statistics
    always_ff @(posedge clk) begin
        runt_cnt <= (sreset || cnts_clear) ? '0 : sat_inc(runt_cnt, push && runt);
    end
`else
    assign runt_cnt = '0;
`endif
endmodule

// File: tb/tb_p4_router_ingress_mtu_guard.sv
// tb_p4_router_ingress_mtu_guard: directed vector table plus corner sequences and a random scoreboard run
`timescale 1ns/1ps
module tb_p4_router_ingress_mtu_guard;
    localparam int DB = 64, UW = 4, PL = 2, MTU = 1500, MINB = 14;
`ifdef P4_ROUTER_ING_GUARD_RUNT_CHECK_EN
    localparam int RUNT = 1;
`else
    localparam int RUNT = 0;
`endif

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [DB-1:0] keep;
        logic [DB*8-1:0] data;
    } beat_t;

    typedef struct {
        int len;
        int exp_out;
        int exp_err;
        int exp_ovs;
        int exp_disc;
        int exp_runt;
    } vec_t;

    logic clk = 0, sreset = 1, enable = 1, cnts_clear = 0;
    logic [DB*8-1:0] ing_tdata = '0;
    logic [DB-1:0]   ing_tkeep = '0;
    logic [UW-1:0]   ing_tuser = '0;
    logic            ing_tlast = 0, ing_tvalid = 0, vnp4_tready = 1;
    logic            ing_tready, vnp4_tlast, vnp4_tvalid;
    logic [DB*8-1:0] vnp4_tdata;
    logic [DB-1:0]   vnp4_tkeep;
    logic [UW-1:0]   vnp4_tuser;
    logic [31:0]     pkt_cnt, oversize_cnt, runt_cnt, discard_beat_cnt;
    logic            s_rdy, s_last, s_valid;
    logic [DB*8-1:0] s_data;
    logic [DB-1:0]   s_keep;
    logic [UW-1:0]   s_user;
    logic [1:0]      s_pkt, s_ovs, s_runt, s_disc;

    p4_router_ingress_mtu_guard #(.MTU_BYTES(MTU), .MIN_PKT_BYTES(MINB), .COUNTER_WIDTH(32),
        .DATA_BYTES(DB), .USER_WIDTH(UW), .NUM_ING_PHYS_PORTS_LOG(PL)) u_dut (
        .clk(clk), .sreset(sreset), .ing_tdata(ing_tdata), .ing_tkeep(ing_tkeep), .ing_tuser(ing_tuser),
        .ing_tlast(ing_tlast), .ing_tvalid(ing_tvalid), .ing_tready(ing_tready),
        .vnp4_tdata(vnp4_tdata), .vnp4_tkeep(vnp4_tkeep), .vnp4_tuser(vnp4_tuser), .vnp4_tlast(vnp4_tlast),
        .vnp4_tvalid(vnp4_tvalid), .vnp4_tready(vnp4_tready), .enable(enable), .cnts_clear(cnts_clear),
        .pkt_cnt(pkt_cnt), .oversize_cnt(oversize_cnt), .runt_cnt(runt_cnt), .discard_beat_cnt(discard_beat_cnt));

    // narrow-counter twin in lockstep with the main instance, used for saturation
    p4_router_ingress_mtu_guard #(.MTU_BYTES(MTU), .MIN_PKT_BYTES(MINB), .COUNTER_WIDTH(2),
        .DATA_BYTES(DB), .USER_WIDTH(UW), .NUM_ING_PHYS_PORTS_LOG(PL)) u_sat (
        .clk(clk), .sreset(sreset), .ing_tdata(ing_tdata), .ing_tkeep(ing_tkeep), .ing_tuser(ing_tuser),
        .ing_tlast(ing_tlast), .ing_tvalid(ing_tvalid), .ing_tready(s_rdy),
        .vnp4_tdata(s_data), .vnp4_tkeep(s_keep), .vnp4_tuser(s_user), .vnp4_tlast(s_last),
        .vnp4_tvalid(s_valid), .vnp4_tready(vnp4_tready), .enable(enable), .cnts_clear(cnts_clear),
        .pkt_cnt(s_pkt), .oversize_cnt(s_ovs), .runt_cnt(s_runt), .discard_beat_cnt(s_disc));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0, in_cyc = 0, first_out = -1, out_cnt = 0, occ = 0;
    int m_pkt = 0, m_ovs = 0, m_runt = 0, m_disc = 0;
    bit rnd_rdy = 0, chk_rdy = 0, cur_fwd = 0, hold_v = 0;
    logic last_err = 0;
    beat_t exp_q[$];
    beat_t out_beat, hold_b;
    vec_t vecs[13];

    assign out_beat = {vnp4_tlast, vnp4_tuser, vnp4_tkeep, vnp4_tdata};

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1 vnp4_tready = rnd_rdy ? 1'($urandom) : 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // output monitor: scoreboard, payload stability, ready-while-free-entry
    always @(negedge clk) begin
        beat_t e;
        if (!sreset && hold_v) begin
            n_chk++;
            if (!vnp4_tvalid || out_beat != hold_b) begin
                n_fail++;
                $display("FAIL hold: valid=%0b user=%h last=%0b, required valid=1 user=%h last=%0b",
                         vnp4_tvalid, vnp4_tuser, vnp4_tlast, hold_b.user, hold_b.last);
            end
        end
        hold_v = vnp4_tvalid && !vnp4_tready && !sreset;
        hold_b = out_beat;
        if (vnp4_tvalid && first_out < 0) first_out = cyc;
        if (chk_rdy && occ < 2) begin
            n_chk++;
            if (!ing_tready) begin
                n_fail++;
                $display("FAIL ready_free: ing_tready=0 with occupancy %0d, required 1", occ);
            end
        end
        if (vnp4_tvalid && vnp4_tready && !sreset) begin
            out_cnt++;
            last_err = vnp4_tuser[UW-1];
            occ--;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat: unexpected output beat user=%h last=%0b", vnp4_tuser, vnp4_tlast);
            end else begin
                e = exp_q.pop_front();
                if (out_beat != e) begin
                    n_fail++;
                    $display("FAIL beat: got last=%0b user=%h keep=%h data=%h required last=%0b user=%h keep=%h data=%h",
                             vnp4_tlast, vnp4_tuser, vnp4_tkeep, vnp4_tdata[63:0], e.last, e.user, e.keep, e.data[63:0]);
                end
            end
        end
        if (ing_tvalid && ing_tready && cur_fwd) occ++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // drives one packet and builds its expected output from the truncation/runt rules
    task automatic send_pkt(input int len, input int drop_at, input int stop_after);
        int nb, acc_b, to;
        bit trunc;
        logic [PL-1:0] port;
        logic spare;
        nb = (len + DB - 1) / DB;
        acc_b = 0;
        trunc = 0;
        port = PL'($urandom);
        spare = 1'($urandom);
        for (int b = 0; b < nb && b < stop_after; b++) begin
            int bytes;
            beat_t bt;
            bytes = (len - b * DB > DB) ? DB : len - b * DB;
            for (int w = 0; w < DB / 4; w++) bt.data[w*32 +: 32] = $urandom;
            bt.keep = {DB{1'b1}} >> (DB - bytes);
            bt.last = (b == nb - 1);
            bt.user = {1'b0, spare, port};
            if (b == drop_at) enable = 0;
            ing_tdata = bt.data;
            ing_tkeep = bt.keep;
            ing_tuser = bt.user;
            ing_tlast = bt.last;
            ing_tvalid = 1;
            cur_fwd = !trunc;
            if (!trunc) begin
                acc_b += bytes;
                if (acc_b > MTU) begin
                    m_ovs++;
                    bt.user[UW-1] = 1'b1;
                    bt.last = 1'b1;
                    trunc = 1;
                end else if (bt.last && acc_b < MINB && RUNT == 1) begin
                    m_runt++;
                    bt.user[UW-1] = 1'b1;
                end
                exp_q.push_back(bt);
            end else m_disc++;
            to = 0;
            do begin
                @(negedge clk);
                to++;
            end while (!ing_tready && to < 200);
            if (!ing_tready) begin
                n_chk++;
                n_fail++;
                $display("FAIL ing_tready_timeout: beat %0d of %0d-byte packet never accepted", b, len);
            end
            if (b == 0) in_cyc = cyc;
            @(posedge clk);
            #1;
        end
        ing_tvalid = 0;
        ing_tlast = 0;
        cur_fwd = 0;
        if (trunc || stop_after >= nb) m_pkt++;
    endtask

    task automatic drain();
        int to;
        to = 0;
        while ((exp_q.size() != 0 || vnp4_tvalid) && to < 5000) begin
            @(negedge clk);
            to++;
        end
        if (to >= 5000) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected beats still outstanding", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_pkt"}, pkt_cnt, m_pkt);
        chk({tag, "_ovs"}, oversize_cnt, m_ovs);
        chk({tag, "_runt"}, runt_cnt, m_runt);
        chk({tag, "_disc"}, discard_beat_cnt, m_disc);
        chk({tag, "_sat_pkt"}, s_pkt, m_pkt > 3 ? 3 : m_pkt);
        chk({tag, "_sat_ovs"}, s_ovs, m_ovs > 3 ? 3 : m_ovs);
        chk({tag, "_sat_runt"}, s_runt, m_runt > 3 ? 3 : m_runt);
        chk({tag, "_sat_disc"}, s_disc, m_disc > 3 ? 3 : m_disc);
    endtask

    initial begin
        longint p0, o0, d0, r0;
        int hi;
        vecs[0]  = '{1500, 24, 0, 0, 0, 0};
        vecs[1]  = '{1600, 24, 1, 1, 1, 0};
        vecs[2]  = '{100,  2,  0, 0, 0, 0};
        vecs[3]  = '{10,   1,  RUNT, 0, 0, RUNT};
        vecs[4]  = '{13,   1,  RUNT, 0, 0, RUNT};
        vecs[5]  = '{14,   1,  0, 0, 0, 0};
        vecs[6]  = '{64,   1,  0, 0, 0, 0};
        vecs[7]  = '{1501, 24, 1, 1, 0, 0};
        vecs[8]  = '{1472, 23, 0, 0, 0, 0};
        vecs[9]  = '{1537, 24, 1, 1, 1, 0};
        vecs[10] = '{3000, 24, 1, 1, 23, 0};
        vecs[11] = '{1536, 24, 1, 1, 0, 0};
        vecs[12] = '{1,    1,  RUNT, 0, 0, RUNT};

        // reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", vnp4_tvalid, 0);
        chk("rst_tready", ing_tready, 0);
        @(posedge clk);
        #1 sreset = 0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_tready", ing_tready, 1);
        chk_counters("rst");
        @(posedge clk);
        #1;

        // directed vector table, one packet per row with the output drained between rows
        for (int i = 0; i < 13; i++) begin
            p0 = pkt_cnt;
            o0 = oversize_cnt;
            d0 = discard_beat_cnt;
            r0 = runt_cnt;
            out_cnt = 0;
            first_out = -1;
            send_pkt(vecs[i].len, -1, 1 << 30);
            drain();
            chk($sformatf("v%0d_beats", vecs[i].len), out_cnt, vecs[i].exp_out);
            chk($sformatf("v%0d_err", vecs[i].len), last_err, vecs[i].exp_err);
            chk($sformatf("v%0d_latency", vecs[i].len), first_out - in_cyc, 1);
            chk($sformatf("v%0d_pkt", vecs[i].len), longint'(pkt_cnt) - p0, 1);
            chk($sformatf("v%0d_ovs", vecs[i].len), longint'(oversize_cnt) - o0, vecs[i].exp_ovs);
            chk($sformatf("v%0d_disc", vecs[i].len), longint'(discard_beat_cnt) - d0, vecs[i].exp_disc);
            chk($sformatf("v%0d_runt", vecs[i].len), longint'(runt_cnt) - r0, vecs[i].exp_runt);
        end
        chk_counters("table");

        // enable dropped on beat 3 of a 5-beat packet
        out_cnt = 0;
        send_pkt(320, 2, 1 << 30);
        drain();
        chk("en_beats", out_cnt, 5);
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (ing_tready) hi++;
        end
        chk("en_stall_ready_high_cycles", hi, 0);
        @(posedge clk);
        #1 enable = 1;
        @(posedge clk);
        @(negedge clk);
        chk("en_resume_ready", ing_tready, 1);
        @(posedge clk);
        #1;
        out_cnt = 0;
        send_pkt(100, -1, 1 << 30);
        drain();
        chk("en_next_beats", out_cnt, 2);

        // clear coincident with the pkt_cnt increment of a single-beat packet
        send_pkt(64, -1, 1 << 30);
        cnts_clear = 1;
        @(posedge clk);
        #1 cnts_clear = 0;
        drain();
        m_pkt = 0;
        m_ovs = 0;
        m_runt = 0;
        m_disc = 0;
        chk_counters("clear");

        // random back-pressure over random-length back-to-back packets
        occ = 0;
        rnd_rdy = 1;
        chk_rdy = 1;
        for (int i = 0; i < 1000; i++) send_pkt($urandom_range(1, 1600), -1, 1 << 30);
        drain();
        chk_rdy = 0;
        rnd_rdy = 0;
        chk_counters("random");

        // reset while discarding the tail of a 1700-byte packet
        send_pkt(1700, -1, 25);
        drain();
        @(negedge clk);
        chk("pre_rst_disc", discard_beat_cnt, m_disc);
        @(posedge clk);
        #1 sreset = 1;
        repeat (2) @(posedge clk);
        #1 sreset = 0;
        exp_q.delete();
        occ = 0;
        m_pkt = 0;
        m_ovs = 0;
        m_runt = 0;
        m_disc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_counters("disc_rst");
        out_cnt = 0;
        send_pkt(100, -1, 1 << 30);
        drain();
        chk("disc_rst_beats", out_cnt, 2);
        chk("disc_rst_err", last_err, 0);
        chk("disc_rst_pkt", pkt_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/p4_router_ingress_mtu_guard.md
# p4_router_ingress_mtu_guard

Per-packet length policer between the ingress buffer's converged `ing_bus` output and the VNP4 input. It counts bytes per packet and forwards conforming packets unchanged with one cycle of latency. Oversize packets are truncated at the first beat that crosses `MTU_BYTES`; that beat gets a forced `tlast` and an error flag, and the remainder of the packet is discarded. It also provides an enable gate that acts only at packet boundaries, plus saturating statistics counters.

## Interface
Parameters:
- `MTU_BYTES`, 1500: largest legal packet in bytes.
- `MIN_PKT_BYTES`, 14: smallest legal packet in bytes. Must be ≤ `ing_bus.DATA_BYTES`.
- `COUNTER_WIDTH`, 32: width of the statistics counters.

Ports:
- `clk`, input, 1: single clock. Both AXIS interfaces are clocked by it.
- `sreset`, input, 1: synchronous, active-high reset. The interfaces' internal `sresetn` is ignored.
- `ing_bus`, AXIS_int.Slave: from the ingress buffer.
  - `tuser[NUM_ING_PHYS_PORTS_LOG-1:0]` carries the physical port index.
- `vnp4_bus`, AXIS_int.Master: to VNP4.
  - Same `DATA_BYTES`/`USER_WIDTH` as `ing_bus`.
  - `tuser[USER_WIDTH-1]` is the error flag.
- `enable`, input, 1: admit new packets.
- `cnts_clear`, input, 1: synchronous clear of all counters.
- `pkt_cnt`, output, `COUNTER_WIDTH`: packets emitted on `vnp4_bus`.
- `oversize_cnt`, output, `COUNTER_WIDTH`: packets flagged oversize.
- `runt_cnt`, output, `COUNTER_WIDTH`: packets flagged runt.
- `discard_beat_cnt`, output, `COUNTER_WIDTH`: input beats dropped in DISCARD.

## Operation
- Elaboration checks:
  - `ing_bus` and `vnp4_bus` have equal `DATA_BYTES` and `USER_WIDTH`.
  - `USER_WIDTH` ≥ `NUM_ING_PHYS_PORTS_LOG`+1.
  - `MIN_PKT_BYTES` ≤ `DATA_BYTES` ≤ `MTU_BYTES`.
- `tkeep` is required to be LSB-contiguous.
  - `beat_bytes` = popcount(`tkeep`).
  - `len` register width is `$clog2(MTU_BYTES+DATA_BYTES+1)`.
  - `next_len` = `len` + `beat_bytes`, computed with no overflow possible.
- States: PASS (reset), DISCARD.
- PASS, accepted beat:
  - Beat forwarded with `tdata`/`tkeep`/port bits unchanged.
  - `next_len` ≤ `MTU_BYTES`: `tlast`/error flag pass through (error subject to the runt rule). `len` becomes `next_len`, or 0 on `tlast`.
  - `next_len` > `MTU_BYTES` with `tlast`=1: error flag=1, `oversize_cnt`+1, `len`←0, stay in PASS.
  - `next_len` > `MTU_BYTES` with `tlast`=0: output `tlast` forced to 1, error flag=1, `oversize_cnt`+1, `len`←0, go to DISCARD.
- DISCARD:
  - `ing_bus.tready`=1 unconditionally; nothing forwarded.
  - Each accepted beat increments `discard_beat_cnt`.
  - On an accepted `tlast`, return to PASS.
- Runt: a packet whose `tlast` beat gives `next_len` < `MIN_PKT_BYTES` is forwarded with error flag=1 and increments `runt_cnt`. No drop.
- Enable gate:
  - In PASS with `len`=0 and `enable`=0: `ing_bus.tready`=0.
  - Deasserting `enable` mid-packet takes effect only after that packet's `tlast`.
- `pkt_cnt` increments on each `vnp4_bus` handshake with `tlast`=1, including truncated packets.
- Counters:
  - Saturate at all-ones.
  - `cnts_clear` wins over a same-cycle increment.
  - Oversize and runt on the same packet both count.

## Timing
- The output stage is a two-entry skid buffer.
  - `ing_bus.tready` is registered and depends only on buffer occupancy, state, `len` and `enable`.
  - Full throughput: one beat per cycle sustained.
- Latency from `ing_bus` handshake to `vnp4_bus.tvalid` is 1 cycle.
- `vnp4_bus.tvalid`, once high, holds with stable payload until `tready`.
- Counters update one cycle after the triggering handshake.
- Reset values:
  - `vnp4_bus.tvalid`=0, `ing_bus.tready`=0 during reset, then 1 the next cycle.
  - State PASS, `len`=0, skid buffer empty, all counters 0.
- `sreset` mid-packet:
  - Skid contents are lost; output resumes clean.
  - Any upstream remainder is treated as a new packet. Upstream is reset together with this block.

## Configuration
- `P4_ROUTER_ING_GUARD_RUNT_CHECK_EN` defined: runt detection, flagging and `runt_cnt` are active as described.
- Undefined: no runt logic is built, `runt_cnt` is tied to 0, and the error flag reflects only oversize.

## Test plan
- 64B bus, `MTU_BYTES`=1500, 1500-byte packet (23 full beats + 28-byte tail), `vnp4_bus.tready`=1:
  - 24 beats out, identical to input, error=0.
  - `pkt_cnt`=1; first output 1 cycle after first input.
- 1600-byte packet:
  - Beat 24 (`next_len`=1536) emitted with `tlast`=1, error=1.
  - Remaining 1 beat dropped.
  - `oversize_cnt`=1, `discard_beat_cnt`=1.
  - The following 100-byte packet passes clean.
- Single-beat packet with `tkeep`=0x3FF (10 bytes):
  - With macro: error=1, `runt_cnt`=1.
  - Without macro: error=0, `runt_cnt`=0.
- Random `vnp4_bus.tready` (50%) over 1000 random-length packets (1–1600 bytes):
  - No beat lost or duplicated; output matches a scoreboard model of the truncation rules.
  - `ing_bus.tready` never drops while the skid buffer has a free entry.
- `enable` dropped at beat 3 of a 5-beat packet:
  - Beats 4–5 accepted; next packet stalled with `tready`=0.
  - Re-enabling resumes the next cycle.
- Counters:
  - Forced to all-ones: they hold under further events.
  - `cnts_clear` coincident with an increment yields 0.
  - `sreset` during DISCARD returns to PASS with all counters 0.
